// File: rtl/cla_bist.sv
// Built-in self-test for the registered CLA adder: sweeps every operand/carry-in
// combination, checks each delayed result against a golden add and latches a verdict.
//   state | meaning
//   IDLE  | outputs parked at 0, waiting for start
//   RUN   | issuing one vector per clock
//   DRAIN | operands at 0 while the last LATENCY results come back
//   DONE  | verdict stable until start or rst
module cla_bist #(
  parameter int WIDTH   = 4,
  parameter int LATENCY = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  output logic [WIDTH-1:0]     A_out,
  output logic [WIDTH-1:0]     B_out,
  output logic                 C0_out,
  input  logic [WIDTH-1:0]     S_in,
  input  logic                 C4_in,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [2*WIDTH+1:0]   err_count,
  output logic [2*WIDTH:0]     first_fail,
  output logic                 fail_seen
);

  localparam int IW = 2*WIDTH+1;
  localparam int EW = 2*WIDTH+2;
  localparam int RW = WIDTH+1;
  localparam int CW = 4;
  localparam logic [IW-1:0] IDX_LAST   = '1;
  localparam logic [CW-1:0] DRAIN_LOAD = CW'(LATENCY-1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic             c0_q, c0_d;
  logic             busy_q, busy_d, done_q, done_d;
  logic [EW-1:0]    err_q, err_d;
  logic [IW-1:0]    first_q, first_d;
  logic             seen_q, seen_d;
  logic [CW-1:0]    drain_q, drain_d;

  logic             dl_v_q[LATENCY],   dl_v_d[LATENCY];
  logic [IW-1:0]    dl_idx_q[LATENCY], dl_idx_d[LATENCY];
  logic [RW-1:0]    dl_exp_q[LATENCY], dl_exp_d[LATENCY];

  logic [RW-1:0]    exp_cur;
  logic [IW-1:0]    idx_nxt;

  assign exp_cur = {1'b0, idx_q[WIDTH-1:0]} + {1'b0, idx_q[2*WIDTH-1:WIDTH]}
                 + RW'(idx_q[2*WIDTH]);
  assign idx_nxt = idx_q + IW'(1);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    a_d     = a_q;
    b_d     = b_q;
    c0_d    = c0_q;
    busy_d  = busy_q;
    done_d  = done_q;
    err_d   = err_q;
    first_d = first_q;
    seen_d  = seen_q;
    drain_d = drain_q;

    // The entry for the vector currently on the operand outputs enters the line
    // one clock after issue, so the head lines up with the adder result.
    dl_v_d[0]   = (state_q == S_RUN);
    dl_idx_d[0] = idx_q;
    dl_exp_d[0] = exp_cur;
    for (int j = 1; j < LATENCY; j++) begin
      dl_v_d[j]   = dl_v_q[j-1];
      dl_idx_d[j] = dl_idx_q[j-1];
      dl_exp_d[j] = dl_exp_q[j-1];
    end

    if (dl_v_q[LATENCY-1] && ({C4_in, S_in} != dl_exp_q[LATENCY-1])) begin
      err_d = err_q + EW'(1);
      if (!seen_q) begin
        first_d = dl_idx_q[LATENCY-1];
        seen_d  = 1'b1;
      end
    end

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_RUN;
          idx_d   = '0;
          a_d     = '0;
          b_d     = '0;
          c0_d    = 1'b0;
          busy_d  = 1'b1;
          done_d  = 1'b0;
          err_d   = '0;
          first_d = '0;
          seen_d  = 1'b0;
        end
      end
      S_RUN: begin
        if (idx_q == IDX_LAST) begin
          state_d = S_DRAIN;
          drain_d = DRAIN_LOAD;
          a_d     = '0;
          b_d     = '0;
          c0_d    = 1'b0;
        end else begin
          idx_d = idx_nxt;
          {c0_d, b_d, a_d} = idx_nxt;
        end
      end
      S_DRAIN: begin
        if (drain_q == '0) begin
          state_d = S_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          drain_d = drain_q - CW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      c0_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= '0;
      first_q <= '0;
      seen_q  <= 1'b0;
      drain_q <= '0;
      for (int j = 0; j < LATENCY; j++) begin
        dl_v_q[j]   <= 1'b0;
        dl_idx_q[j] <= '0;
        dl_exp_q[j] <= '0;
      end
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      a_q     <= a_d;
      b_q     <= b_d;
      c0_q    <= c0_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      first_q <= first_d;
      seen_q  <= seen_d;
      drain_q <= drain_d;
      for (int j = 0; j < LATENCY; j++) begin
        dl_v_q[j]   <= dl_v_d[j];
        dl_idx_q[j] <= dl_idx_d[j];
        dl_exp_q[j] <= dl_exp_d[j];
      end
    end
  end

  assign A_out      = a_q;
  assign B_out      = b_q;
  assign C0_out     = c0_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign pass       = done_q && (err_q == '0);
  assign err_count  = err_q;
  assign first_fail = first_q;
  assign fail_seen  = seen_q;

endmodule

// File: tb/tb_cla_bist.sv
// Bench for cla_bist: a configurable adder model (golden, stuck bits, wrong latency)
// feeds the BIST, and each sweep's verdict is checked against an exhaustive reference.
module tb_cla_bist;

  localparam int N = 512;
  localparam int L = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [3:0] A_out, B_out, S_in;
  logic       C0_out, C4_in;
  logic       busy, done, pass, fail_seen;
  logic [9:0] err_count;
  logic [8:0] first_fail;

  int checks = 0;
  int errors = 0;

  // adder model configuration: 0 golden, 1 S bit stuck, 2 C4 stuck-at-0, 3 golden but 3-cycle latency
  int model_mode = 0;
  int model_bit  = 0;
  int model_val  = 0;

  logic [4:0] pipe[3];
  logic [4:0] model_out;

  cla_bist #(.WIDTH(4), .LATENCY(L)) dut (
    .clk(clk), .rst(rst), .start(start),
    .A_out(A_out), .B_out(B_out), .C0_out(C0_out),
    .S_in(S_in), .C4_in(C4_in),
    .busy(busy), .done(done), .pass(pass),
    .err_count(err_count), .first_fail(first_fail), .fail_seen(fail_seen)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    pipe[0] <= {1'b0, A_out} + {1'b0, B_out} + 5'(C0_out);
    pipe[1] <= pipe[0];
    pipe[2] <= pipe[1];
  end

  always_comb begin
    model_out = (model_mode == 3) ? pipe[2] : pipe[1];
    if (model_mode == 1) model_out[model_bit] = model_val[0];
    if (model_mode == 2) model_out[4] = 1'b0;
  end
  assign {C4_in, S_in} = model_out;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int gold(input int i);
    return (i & 15) + ((i >> 4) & 15) + ((i >> 8) & 1);
  endfunction

  // Exhaustive reference: what the adder shows for each vector vs. the true sum.
  function automatic void ref_sweep(input int mode, input int fb, input int fv,
                                    output int e, output int f);
    e = 0;
    f = 0;
    for (int i = 0; i < N; i++) begin
      int obs;
      obs = gold(i);
      if (mode == 1) obs = fv ? (obs | (1 << fb)) : (obs & ~(1 << fb));
      if (mode == 2) obs = obs & 15;
      if (mode == 3) obs = (i == 0) ? 0 : gold(i - 1);
      if (obs != gold(i)) begin
        if (e == 0) f = i;
        e++;
      end
    end
  endfunction

  task automatic run_sweep(input string tag, input int mode, input int fb, input int fv,
                           input bit hold, input int rst_at);
    int e_exp, f_exp, cnt, opnd_bad, busy_drop;
    model_mode = mode;
    model_bit  = fb;
    model_val  = fv;
    ref_sweep(mode, fb, fv, e_exp, f_exp);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    if (!hold) start = 1'b0;
    chk({tag, ":busy_rise"}, int'(busy), 1);
    chk({tag, ":done_clr"}, int'(done), 0);
    cnt = 0;
    opnd_bad = 0;
    busy_drop = 0;
    while (!done && cnt < N + L + 20) begin
      if (rst_at > 0 && cnt == rst_at) begin
        chk({tag, ":pre_rst_err"}, int'(err_count != 0), 1);
        rst = 1'b1;
        #1;
        chk({tag, ":rst_busy"}, int'(busy), 0);
        chk({tag, ":rst_ops"}, int'({C0_out, B_out, A_out}), 0);
        chk({tag, ":rst_err"}, int'(err_count), 0);
        chk({tag, ":rst_seen"}, int'(fail_seen), 0);
        @(negedge clk);
        rst = 1'b0;
        return;
      end
      if (int'({C0_out, B_out, A_out}) != ((cnt < N) ? cnt : 0)) opnd_bad++;
      if (!busy) busy_drop++;
      if (hold && cnt == N) start = 1'b0;
      @(posedge clk);
      #1;
      cnt++;
    end
    chk({tag, ":cycles"}, cnt, N + L);
    chk({tag, ":operands"}, opnd_bad, 0);
    chk({tag, ":busy_gap"}, busy_drop, 0);
    chk({tag, ":busy_fall"}, int'(busy), 0);
    chk({tag, ":done"}, int'(done), 1);
    chk({tag, ":err_count"}, int'(err_count), e_exp);
    chk({tag, ":first_fail"}, int'(first_fail), f_exp);
    chk({tag, ":fail_seen"}, int'(fail_seen), int'(e_exp != 0));
    chk({tag, ":pass"}, int'(pass), int'(e_exp == 0));
    repeat (4) @(posedge clk);
    #1;
    chk({tag, ":done_hold"}, int'(done && !busy), 1);
    chk({tag, ":err_hold"}, int'(err_count), e_exp);
  endtask

  initial begin
    repeat (4) @(posedge clk);
    #1;
    chk("reset:busy", int'(busy), 0);
    chk("reset:done", int'(done), 0);
    chk("reset:pass", int'(pass), 0);
    chk("reset:ops", int'({C0_out, B_out, A_out}), 0);
    chk("reset:err", int'(err_count), 0);
    chk("reset:first", int'(first_fail), 0);
    chk("reset:seen", int'(fail_seen), 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("idle:busy", int'(busy), 0);

    run_sweep("golden", 0, 0, 0, 1'b0, 0);
    run_sweep("s0_stuck0", 1, 0, 0, 1'b0, 0);
    run_sweep("c4_stuck0", 2, 0, 0, 1'b0, 0);
    run_sweep("lat3", 3, 0, 0, 1'b0, 0);
    run_sweep("golden_after_lat3", 0, 0, 0, 1'b0, 0);
    run_sweep("start_held", 0, 0, 0, 1'b1, 0);
    run_sweep("repeat", 0, 0, 0, 1'b0, 0);
    run_sweep("rst_mid", 1, 0, 0, 1'b0, 100);
    run_sweep("after_rst", 0, 0, 0, 1'b0, 0);

    for (int r = 0; r < 3; r++) begin
      int m, b, v;
      m = int'($urandom_range(0, 3));
      b = int'($urandom_range(0, 3));
      v = int'($urandom_range(0, 1));
      repeat ($urandom_range(1, 20)) @(posedge clk);
      run_sweep($sformatf("rand%0d_m%0d_b%0d_v%0d", r, m, b, v), m, b, v, 1'b0, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
